// File: rtl/lookup_pkg.sv
// ---------------------------------------------------------------------------
// lookup_pkg
// Purpose : shared definitions for the match-action lookup path. Holds the
//           default bus widths, the action word layout consumed by
//           action_engine, and the no-op action returned on a table miss.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package lookup_pkg;

    localparam int DEF_KEY_LEN    = 896;
    localparam int DEF_MASK_LEN   = 896;
    localparam int DEF_PHV_LEN    = 1579;
    localparam int DEF_ACTION_LEN = 25;

    // Action word as decoded by action_engine (MSB first, 25 bits total).
    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  dst_type;
        logic [2:0]  dst_idx;
        logic [1:0]  src_type;
        logic [2:0]  src_idx;
        logic [10:0] imm;
    } action_t;

    // All-zero action: action_engine treats op == 0 as "leave the PHV alone".
    localparam action_t NOOP_ACTION = '0;

endpackage

// File: rtl/lookup_prio_enc.sv
// ---------------------------------------------------------------------------
// lookup_prio_enc
// Purpose : priority encoder over the per-entry match vector. The lowest set
//           bit wins, so lower table indices take precedence.
// Ports   : i_vec  in  DEPTH        match vector (bit i = entry i matched)
//           o_hit  out 1            at least one bit of i_vec is set
//           o_idx  out log2(DEPTH)  index of the lowest set bit (0 on miss)
// ---------------------------------------------------------------------------
module lookup_prio_enc #(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_vec,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_hit = |i_vec;
        o_idx = '0;
        // Scan from the top down so the last assignment is the lowest index.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lookup_engine.sv
// ---------------------------------------------------------------------------
// lookup_engine
// Purpose : ternary match table in front of action_engine. Each key is
//           compared against DEPTH (key, mask) entries; the lowest-index
//           matching entry supplies the action word, a miss returns the
//           no-op action. Two-stage pipeline, one key per cycle, no
//           backpressure. The PHV travels alongside unchanged.
//
//   Stage 1: register the DEPTH-bit match vector and the PHV.
//   Stage 2: priority-encode, read the action, register the outputs.
//
// Ports   : axis_clk          in   clock
//           areset            in   asynchronous active-high reset
//           key_in/key_valid  in   lookup key and its valid strobe
//           phv_in            in   PHV accompanying the key
//           cfg_wr_en         in   table write strobe
//           cfg_addr          in   entry index being written
//           cfg_key/cfg_mask  in   entry key and ternary mask (1 = compare)
//           cfg_action        in   entry action word
//           cfg_entry_vld     in   entry enable (0 disables the entry)
//           action_out        out  matched action or all zeros on miss
//           action_out_valid  out  result strobe, 2 cycles after key_valid
//           phv_out           out  phv_in delayed by 2 cycles
//           hit_out           out  1 when some entry matched
//           hit_cnt/miss_cnt  out  saturating result counters, present only
//                                  when LOOKUP_ENGINE_HIT_CNT_EN is defined
//
// Handshake: key_valid is a one-cycle qualifier with no ready; every key
// presented is accepted and produces exactly one action_out_valid pulse.
// ---------------------------------------------------------------------------
module lookup_engine
    import lookup_pkg::*;
#(
    parameter  int KEY_LEN    = DEF_KEY_LEN,
    parameter  int MASK_LEN   = DEF_MASK_LEN,
    parameter  int PHV_LEN    = DEF_PHV_LEN,
    parameter  int ACTION_LEN = DEF_ACTION_LEN,
    parameter  int DEPTH      = 16,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  axis_clk,
    input  logic                  areset,
    input  logic [KEY_LEN-1:0]    key_in,
    input  logic                  key_valid,
    input  logic [PHV_LEN-1:0]    phv_in,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [KEY_LEN-1:0]    cfg_key,
    input  logic [MASK_LEN-1:0]   cfg_mask,
    input  logic [ACTION_LEN-1:0] cfg_action,
    input  logic                  cfg_entry_vld,
    output logic [ACTION_LEN-1:0] action_out,
    output logic                  action_out_valid,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic                  hit_out
`ifdef LOOKUP_ENGINE_HIT_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    // Table storage. Only the enable bits are reset; key/mask/action content
    // of a disabled entry is never observed.
    logic [KEY_LEN-1:0]    r_key    [DEPTH];
    logic [MASK_LEN-1:0]   r_mask   [DEPTH];
    logic [ACTION_LEN-1:0] r_action [DEPTH];
    logic [DEPTH-1:0]      r_entry_vld;

    logic [DEPTH-1:0]      w_match;
    logic                  r_s1_valid;
    logic [DEPTH-1:0]      r_s1_match;
    logic [PHV_LEN-1:0]    r_s1_phv;
    logic                  w_hit;
    logic [ADDR_W-1:0]     w_idx;

    always_ff @(posedge axis_clk) begin
        if (cfg_wr_en) begin
            r_key[cfg_addr]    <= cfg_key;
            r_mask[cfg_addr]   <= cfg_mask;
            r_action[cfg_addr] <= cfg_action;
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            r_entry_vld <= '0;
        end else if (cfg_wr_en) begin
            r_entry_vld[cfg_addr] <= cfg_entry_vld;
        end
    end

    // Compare against the registered table, so a write landing on the same
    // edge as a key capture is seen only by the following key.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_entry_vld[i] &&
                         ((key_in & r_mask[i]) == (r_key[i] & r_mask[i]));
        end
    end

    // Stage 1
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
            r_s1_phv   <= '0;
        end else begin
            r_s1_valid <= key_valid;
            if (key_valid) begin
                r_s1_match <= w_match;
                r_s1_phv   <= phv_in;
            end
        end
    end

    lookup_prio_enc #(
        .DEPTH (DEPTH)
    ) u_prio_enc (
        .i_vec (r_s1_match),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    // Stage 2: outputs only change on a valid result and hold otherwise.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            action_out_valid <= 1'b0;
            action_out       <= ACTION_LEN'(NOOP_ACTION);
            hit_out          <= 1'b0;
            phv_out          <= '0;
        end else begin
            action_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                hit_out    <= w_hit;
                action_out <= w_hit ? r_action[w_idx] : ACTION_LEN'(NOOP_ACTION);
                phv_out    <= r_s1_phv;
            end
        end
    end

`ifdef LOOKUP_ENGINE_HIT_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_s1_valid) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
